mem_stage: RTL

Sequential Y86-64 memory stage that consumes the execute stage's results (icode, valE, valA, valP) over a valid/ready handshake. It performs the 8-byte data-memory access one byte per cycle, little-endian, and returns valM plus a status code to write-back. It owns the data memory and the status logic for halt, address and instruction errors.

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/dmem_bytes.sv | 26 ++
 rtl/mem_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 memory stage.
//   - icode constants for every Y86-64 instruction class
//   - stat codes returned to write-back
//   - FSM state encoding for the memory stage
//   - helpers that classify an icode as a store or a load
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic isStore(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

  function automatic logic isLoad(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/dmem_bytes.sv
// dmem_bytes: byte-wide data memory, MEM_BYTES entries.
//   clk       - write clock
//   we_i      - write enable (synchronous write)
//   addr_i    - shared read/write byte address
//   wdata_i   - byte to write
//   rdata_o   - combinational read of the addressed byte
// Contents are never reset.
module dmem_bytes #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(MEM_BYTES)-1:0] addr_i,
  input  logic [7:0]                   wdata_i,
  output logic [7:0]                   rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: sequential Y86-64 memory stage.
// Accepts an execute result over in_valid/in_ready, moves an 8-byte
// little-endian word one byte per cycle and returns valM/stat over
// out_valid/out_ready.
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready         - execute-side handshake (ready only in IDLE)
//   icode, valE, valA, valP   - execute results
//   out_valid/out_ready       - write-back handshake (held until accepted)
//   valM, stat                - loaded word and status code
//   ld_en, ld_addr, ld_data   - byte loader, honoured only in IDLE
module mem_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] valM,
  output logic [1:0]  stat,
  input  logic        ld_en,
  input  logic [63:0] ld_addr,
  input  logic [7:0]  ld_data
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   valM_q, valM_d;
  logic [1:0]    stat_q, stat_d;
  logic          isWrite_q, isWrite_d;

  logic          inStore, inLoad;
  logic [63:0]   inAddr, inData;
  logic [1:0]    inStat;

  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [7:0]    memWdata, memRdata;

  // Decode the presented request. The ADR test uses 65-bit arithmetic so
  // that an address near 2^64 cannot wrap around into the valid range.
  always_comb begin
    inStore = isStore(icode);
    inLoad  = isLoad(icode);
    inAddr  = ((icode == IRET) || (icode == IPOPQ)) ? valA : valE;
    inData  = (icode == ICALL) ? valP : valA;
    if (icode == IHALT)
      inStat = SHLT;
    else if (icode > IPOPQ)
      inStat = SINS;
    else if ((inStore || inLoad) && (({1'b0, inAddr} + 65'd7) >= MEM_LIMIT))
      inStat = SADR;
    else
      inStat = SAOK;
  end

  // Next-state logic for the IDLE -> XFER -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valM_d    = valM_q;
    stat_d    = stat_q;
    isWrite_d = isWrite_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d    = inAddr[AW-1:0];
          data_d    = inData;
          isWrite_d = inStore;
          valM_d    = '0;
          stat_d    = inStat;
          cnt_d     = '0;
          state_d   = ((inStore || inLoad) && (inStat == SAOK)) ? XFER : DONE;
        end
      end
      XFER: begin
        if (!isWrite_q) valM_d[{cnt_q, 3'b000} +: 8] = memRdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valM_q    <= '0;
      stat_q    <= SAOK;
      isWrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valM_q    <= valM_d;
      stat_q    <= stat_d;
      isWrite_q <= isWrite_d;
    end
  end

  // Single memory port: XFER owns it; otherwise the loader may write in
  // IDLE. The write is not gated by rst, so a byte moving on the reset
  // edge still lands, and earlier bytes of an aborted store stay written.
  always_comb begin
    if (state_q == XFER) begin
      memAddr  = addr_q + {{(AW-3){1'b0}}, cnt_q};
      memWe    = isWrite_q;
      memWdata = data_q[{cnt_q, 3'b000} +: 8];
    end else begin
      memAddr  = ld_addr[AW-1:0];
      memWe    = (state_q == IDLE) && ld_en && (ld_addr[63:AW] == '0);
      memWdata = ld_data;
    end
  end

  dmem_bytes #(.MEM_BYTES(MEM_BYTES)) u_dmem (
    .clk     (clk),
    .we_i    (memWe),
    .addr_i  (memAddr),
    .wdata_i (memWdata),
    .rdata_o (memRdata)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign valM      = valM_q;
  assign stat      = stat_q;

endmodule
